// File: rtl/draw_tank_pkg.sv
// rtl/draw_tank_pkg.sv - shared encodings and sizes for the tank sprite compositor
// Window test helper keeps the 12-bit no-wrap arithmetic in one place.
package draw_tank_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_RIGHT = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    localparam int          SPRITE_SIZE   = 64;
    localparam int          ADDR_W        = 12;
    localparam int          RGB_W         = 12;
    localparam int          COORD_W       = 11;
    localparam logic [11:0] KEY_COLOR_DEF = 12'hF0F;

    // One extra bit so a sprite hanging past 2047 never wraps back to 0.
    function automatic logic in_span(input logic [COORD_W-1:0] c,
                                     input logic [COORD_W-1:0] p,
                                     input logic [COORD_W:0]   len);
        return ({1'b0, c} >= {1'b0, p}) && ({1'b0, c} < ({1'b0, p} + len));
    endfunction

endpackage

// File: rtl/draw_tank_if.sv
// rtl/draw_tank_if.sv - image ROM bus: address out, four image words back
// The master side is the compositor, the slave side is the external selector/ROMs.
interface draw_tank_if;
    import draw_tank_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [RGB_W-1:0]  rgb0;
    logic [RGB_W-1:0]  rgb1;
    logic [RGB_W-1:0]  rgb2;
    logic [RGB_W-1:0]  rgb3;

    modport master (
        output address,
        input  rgb0,
        input  rgb1,
        input  rgb2,
        input  rgb3
    );

    modport slave (
        input  address,
        output rgb0,
        output rgb1,
        output rgb2,
        output rgb3
    );

endinterface

// File: rtl/signal_delay.sv
// rtl/signal_delay.sv - fixed-depth shift register with asynchronous active-low clear
module signal_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/draw_tank.sv
// rtl/draw_tank.sv - 3-stage tank sprite compositor over a VGA pixel stream
// Define TANK_TRANSPARENCY_EN to let KEY_COLOR ROM pixels show the background.
module draw_tank
    import draw_tank_pkg::*;
#(
    parameter int          SPRITE_W  = 64,
    parameter int          SPRITE_H  = 64,
    parameter logic [11:0] KEY_COLOR = KEY_COLOR_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] hcount_in,
    input  logic [COORD_W-1:0] vcount_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               hblnk_in,
    input  logic               vblnk_in,
    input  logic [RGB_W-1:0]   rgb_in,
    input  logic [COORD_W-1:0] xpos,
    input  logic [COORD_W-1:0] ypos,
    input  logic [1:0]         direction,
    output logic [COORD_W-1:0] hcount_out,
    output logic [COORD_W-1:0] vcount_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               hblnk_out,
    output logic               vblnk_out,
    output logic [RGB_W-1:0]   rgb_out,
    draw_tank_if.master        rom
);

    localparam int COL_BITS = $clog2(SPRITE_W);
    localparam int ROW_BITS = $clog2(SPRITE_H);
    localparam int TIM_W    = 2 * COORD_W + 4;

`ifdef TANK_TRANSPARENCY_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    // Timing and counters travel untouched through a plain delay line.
    logic [TIM_W-1:0] tim_d;

    signal_delay #(
        .WIDTH (TIM_W),
        .DEPTH (3)
    ) u_timing_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in}),
        .dout  (tim_d)
    );

    assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = tim_d;

    // Image choice is latched once per frame so a visible frame never switches sprites.
    logic vblnk_q;
    dir_t dir_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_q <= 1'b0;
            dir_q   <= DIR_UP;
        end else begin
            vblnk_q <= vblnk_in;
            if (vblnk_in && !vblnk_q) begin
                dir_q <= dir_t'(direction);
            end
        end
    end

    logic                win_c;
    logic [COL_BITS-1:0] dcol;
    logic [ROW_BITS-1:0] drow;

    assign win_c = in_span(hcount_in, xpos, (COORD_W+1)'(SPRITE_W)) &&
                   in_span(vcount_in, ypos, (COORD_W+1)'(SPRITE_H));
    assign dcol  = hcount_in[COL_BITS-1:0] - xpos[COL_BITS-1:0];
    assign drow  = vcount_in[ROW_BITS-1:0] - ypos[ROW_BITS-1:0];

    logic              win1, win2;
    logic              blnk1, blnk2;
    logic [RGB_W-1:0]  rgb1, rgb2;
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win1   <= 1'b0;
            blnk1  <= 1'b0;
            rgb1   <= '0;
            addr_q <= '0;
            win2   <= 1'b0;
            blnk2  <= 1'b0;
            rgb2   <= '0;
        end else begin
            win1   <= win_c;
            blnk1  <= hblnk_in || vblnk_in;
            rgb1   <= rgb_in;
            addr_q <= win_c ? {drow, dcol} : '0;
            win2   <= win1;
            blnk2  <= blnk1;
            rgb2   <= rgb1;
        end
    end

    assign rom.address = addr_q;

    logic [RGB_W-1:0] rom_px;
    logic             use_rom;

    always_comb begin
        rom_px = rom.rgb0;
        case (dir_q)
            DIR_UP:    rom_px = rom.rgb0;
            DIR_DOWN:  rom_px = rom.rgb1;
            DIR_RIGHT: rom_px = rom.rgb2;
            DIR_LEFT:  rom_px = rom.rgb3;
            default:   rom_px = rom.rgb0;
        endcase
    end

    assign use_rom = win2 && !(TRANSP_EN && (rom_px == KEY_COLOR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out <= '0;
        end else if (blnk2) begin
            rgb_out <= '0;
        end else begin
            rgb_out <= use_rom ? rom_px : rgb2;
        end
    end

endmodule

// File: tb/tb_draw_tank.sv
// tb/tb_draw_tank.sv - directed scoreboard bench for draw_tank
module tb_draw_tank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [10:0] xpos = '0, ypos = '0;
    logic [1:0]  direction = '0;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    draw_tank_if rom_if ();

    draw_tank dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .xpos       (xpos),
        .ypos       (ypos),
        .direction  (direction),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out),
        .rom        (rom_if.master)
    );

    always #5 clk = ~clk;

    // ROM stub: row1/col1 holds the key colour, elsewhere image id tagged onto the address.
    function automatic logic [11:0] rom_val(input int img, input logic [11:0] a);
        logic [1:0] id;
        id = img[1:0];
        if (a == 12'h041) return 12'hF0F;
        return {id, a[9:0]};
    endfunction

    always_ff @(posedge clk) begin
        rom_if.rgb0 <= rom_val(0, rom_if.address);
        rom_if.rgb1 <= rom_val(1, rom_if.address);
        rom_if.rgb2 <= rom_val(2, rom_if.address);
        rom_if.rgb3 <= rom_val(3, rom_if.address);
    end

    typedef struct {
        logic [10:0] hc;
        logic [10:0] vc;
        logic [3:0]  tim;
        logic        win;
        logic [11:0] addr;
        logic [11:0] bg;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   mdir  = 0;
    logic mvb_q = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hcount"}, 32'(hcount_out), 32'h0);
        check({tag, "_vcount"}, 32'(vcount_out), 32'h0);
        check({tag, "_timing"}, 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'h0);
        check({tag, "_rgb"}, 32'(rgb_out), 32'h0);
        check({tag, "_address"}, 32'(rom_if.address), 32'h0);
    endtask

    task automatic do_reset(input string tag);
        exp_t z;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero({tag, "_immediate"});
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all_zero({tag, "_held"});
        #1;
        rst_n = 1'b1;
        sbq.delete();
        z = '{hc: '0, vc: '0, tim: '0, win: 1'b0, addr: '0, bg: '0};
        sbq.push_back(z);
        sbq.push_back(z);
        mdir  = 0;
        mvb_q = 1'b0;
    endtask

    task automatic drive_px(input int hc, input int vc, input logic hs, input logic vs,
                            input logic hb, input logic vb, input logic [11:0] bg);
        exp_t e;
        exp_t p;
        int   x, y, ea;
        logic [11:0] romv, exp_rgb;
        @(negedge clk);
        hcount_in = 11'(hc);
        vcount_in = 11'(vc);
        hsync_in  = hs;
        vsync_in  = vs;
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = bg;
        x = int'(xpos);
        y = int'(ypos);
        e.win = (hc >= x) && (hc < x + 64) && (vc >= y) && (vc < y + 64);
        ea    = e.win ? ((vc - y) * 64 + (hc - x)) : 0;
        e.addr = 12'(ea);
        e.hc   = 11'(hc);
        e.vc   = 11'(vc);
        e.tim  = {hs, vs, hb, vb};
        e.bg   = bg;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        check("address", 32'(rom_if.address), 32'(e.addr));
        if (sbq.size() >= 3) begin
            p = sbq.pop_front();
            romv = rom_val(mdir, p.addr);
            if (p.tim[1] || p.tim[0]) exp_rgb = 12'h000;
            else if (!p.win) exp_rgb = p.bg;
`ifdef TANK_TRANSPARENCY_EN
            else if (romv == 12'hF0F) exp_rgb = p.bg;
`endif
            else exp_rgb = romv;
            check("hcount_out", 32'(hcount_out), 32'(p.hc));
            check("vcount_out", 32'(vcount_out), 32'(p.vc));
            check("sync_blank_out", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'(p.tim));
            check("rgb_out", 32'(rgb_out), 32'(exp_rgb));
        end
        if (vb && !mvb_q) mdir = int'(direction);
        mvb_q = vb;
    endtask

    task automatic line_end(input int vc);
        drive_px(1100, vc, 1'b0, 1'b0, 1'b1, 1'b0, 12'h777);
        drive_px(1101, vc, 1'b0, 1'b0, 1'b1, 1'b0, 12'h777);
    endtask

    initial begin
        do_reset("reset_init");

        xpos = 11'd100;
        ypos = 11'd50;
        direction = 2'd0;
        for (int h = 96; h <= 168; h++)
            drive_px(h, 50, (h == 120), 1'b0, 1'b0, 1'b0, 12'(h + 12'h300));
        line_end(50);
        for (int h = 99; h <= 103; h++)
            drive_px(h, 51, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
        line_end(51);
        for (int h = 108; h <= 112; h++)
            drive_px(h, 60, 1'b0, 1'b0, (h == 110), 1'b0, 12'h456);
        line_end(60);
        for (int h = 160; h <= 166; h++)
            drive_px(h, 113, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0C3);
        line_end(113);
        for (int h = 99; h <= 102; h++)
            drive_px(h, 114, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0AA);
        line_end(114);

        ypos = 11'd180;
        drive_px(98, 200, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111);
        direction = 2'd2;
        for (int h = 99; h <= 104; h++)
            drive_px(h, 200, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111);
        line_end(200);
        for (int i = 0; i < 3; i++)
            drive_px(i, 600, 1'b0, 1'b1, 1'b1, 1'b1, 12'h222);
        drive_px(3, 600, 1'b0, 1'b0, 1'b1, 1'b0, 12'h222);
        for (int h = 98; h <= 104; h++)
            drive_px(h, 200, 1'b0, 1'b0, 1'b0, 1'b0, 12'h333);
        line_end(200);

        xpos = 11'd1000;
        for (int h = 1020; h <= 1023; h++)
            drive_px(h, 190, 1'b0, 1'b0, 1'b0, 1'b0, 12'h444);
        for (int h = 0; h <= 2; h++)
            drive_px(h, 191, 1'b0, 1'b0, 1'b0, 1'b0, 12'h555);

        do_reset("reset_mid");
        xpos = 11'd100;
        for (int h = 100; h <= 103; h++)
            drive_px(h, 200, 1'b0, 1'b0, 1'b0, 1'b0, 12'h666);
        line_end(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/draw_tank.md
DRAW_TANK -- requirements
Module: draw_tank

Interface
REQ-001 SHALL have parameter SPRITE_W, default 64, meaning sprite width in pixels (address column bits = 6).
REQ-002 SHALL have parameter SPRITE_H, default 64, meaning sprite height in pixels (address row bits = 6).
REQ-003 SHALL have parameter KEY_COLOR, default 12'hF0F, meaning transparent colour value.
REQ-004 SHALL have port clk  input  1  system pixel clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports hcount_in / vcount_in  input  11 each  current pixel coordinates.
REQ-007 SHALL have ports hsync_in, vsync_in, hblnk_in, vblnk_in  input  1 each  VGA timing.
REQ-008 SHALL have port rgb_in  input  12  background pixel colour.
REQ-009 SHALL have ports xpos / ypos  input  11 each  tank top-left corner.
REQ-010 SHALL have port direction  input  2  requested image: 0 up, 1 down, 2 right, 3 left.
REQ-011 SHALL have ports rgb0..rgb3  input  12 each  image ROM data (up, down, right, left), 1-cycle synchronous read.
REQ-012 SHALL have port address  output  12  image ROM address {row[5:0], col[5:0]}.
REQ-013 SHALL have ports hcount_out, vcount_out (11), hsync_out, vsync_out, hblnk_out, vblnk_out (1)  output  delayed timing.
REQ-014 SHALL have port rgb_out  output  12  composited pixel.

Function
REQ-015 SHALL delay every timing/count input to its *_out by exactly 3 clocks.
REQ-016 Stage 1 SHALL register in_win = (hcount_in >= xpos) && (hcount_in < xpos+SPRITE_W) && same for vcount/ypos, with sums computed 12 bits wide (no wrap at 2047).
REQ-017 Stage 1 SHALL register address = {vcount_in-ypos, hcount_in-xpos} truncated to 6+6 bits when in_win, else 12'h000.
REQ-018 Stage 2 SHALL carry in_win and rgb_in one clock while the ROM returns data.
REQ-019 Stage 3 SHALL register rgb_out = 12'h000 if delayed hblnk or vblnk; else ROM data selected by dir_q if in_win; else delayed rgb_in.
REQ-020 SHALL hold a frame-direction register dir_q, loaded from direction only on the rising edge of vblnk_in (detected against a registered copy).
REQ-021 direction changes mid-frame SHALL take effect on the next frame only; no image switch inside a visible frame.
REQ-022 Sprite partially past screen edge SHALL draw only the visible part; xpos=0/ypos=0 SHALL draw column/row 0 at pixel 0.
REQ-023 SHALL be a fixed pipeline: no stalls, one pixel per clock, state = pipeline regs + dir_q + vblnk edge reg.

Reset
REQ-024 rst_n low SHALL asynchronously clear all pipeline registers, address, rgb_out and all *_out to 0.
REQ-025 rst_n low SHALL set dir_q to 0 (up) and the vblnk edge register to 0.
REQ-026 After reset release mid-frame, outputs SHALL be valid from the 3rd clock; dir_q SHALL stay up until the next vblnk rising edge.

Configuration
REQ-027 Macro TANK_TRANSPARENCY_EN defined: in-window ROM pixel equal to KEY_COLOR SHALL output delayed rgb_in instead.
REQ-028 Macro undefined: ROM pixel SHALL be output unconditionally in-window, KEY_COLOR ignored.

Structure
REQ-029 Shared package SHALL hold direction encodings (DIR_UP=0, DIR_DOWN=1, DIR_RIGHT=2, DIR_LEFT=3), sprite size 64, address width 12, default KEY_COLOR.
REQ-030 SHALL instantiate one sub-module, signal_delay (parameterised width/depth shift register with async active-low reset), for the 3-clock timing delay.
REQ-031 ROMs SHALL remain outside; address drives the existing four-image selector, rgb0..rgb3 return from it.

Verification
REQ-032 xpos=100, ypos=50, pixel (100,50) -> address 12'h000; pixel (163,113) -> 12'hFFF; pixel (164,50) -> rgb_out = background.
REQ-033 direction 0->2 while vcount=200 visible -> rgb0 used to frame end, rgb2 from first pixel after next vblnk rise.
REQ-034 ROM stub returns 12'hF0F at sprite pixel, rgb_in=12'h123 -> rgb_out 12'h123 with TANK_TRANSPARENCY_EN, 12'hF0F without.
REQ-035 xpos=1000, screen width 1024, hcount 1023 -> address col 23, sprite drawn; hcount 0 next line -> no wrap, background.
REQ-036 hsync_in pulse at cycle N -> hsync_out pulse at N+3; hblnk high inside sprite window -> rgb_out 12'h000.
REQ-037 rst_n low for 2 clocks mid-line -> all outputs 0 immediately; dir_q = up after release until next vblnk rise.
